// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Registered decode stage between instruction fetch and the immediate
//   extender / register file of the multicycle RV32I core. Instruction words
//   arrive over a valid/ready handshake, are decoded on the input side, and are
//   held in a two-entry skid buffer (main + skid) so the stage sustains one
//   instruction per cycle while o_ready stays a plain register output.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   i_rst      synchronous active-high reset (priority over i_flush)
//   i_flush    drop every buffered instruction and the word offered this cycle
//   i_instr    instruction word from fetch, qualified by i_valid
//   i_valid    upstream offers i_instr
//   o_ready    stage can accept a word this cycle (registered)
//   o_valid    decoded outputs valid
//   i_ready    downstream consumes the decoded outputs this cycle
//   o_imm      instr[31:7] for the immediate extender
//   o_imm_src  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U, 101 CSR-imm
//   o_opcode, o_rd, o_rs1, o_rs2, o_func3, o_func7_5   raw instruction fields
//   o_illegal  opcode outside RV32I or instr[1:0] != 2'b11

module instr_decode_stage #(
    parameter int INSTR_WIDTH = 32,
    parameter int IMM_WIDTH   = 25
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [IMM_WIDTH-1:0]   o_imm,
    output logic [2:0]             o_imm_src,
    output logic [6:0]             o_opcode,
    output logic [4:0]             o_rd,
    output logic [4:0]             o_rs1,
    output logic [4:0]             o_rs2,
    output logic [2:0]             o_func3,
    output logic                   o_func7_5,
    output logic                   o_illegal
);

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_CSR = 3'b101
    } imm_src_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        imm_src_t               src;
        logic                   illegal;
    } dec_t;

    state_t state;
    dec_t   dec_in;
    dec_t   main_q;
    dec_t   skid_q;
    logic   ready_q;
    logic   valid_q;
    logic   accept;
    logic   consume;

    // Decode on the input side so both buffer entries hold finished results.
    always_comb begin
        dec_in.instr   = i_instr;
        dec_in.src     = IMM_I;
        dec_in.illegal = 1'b0;
        case (i_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b0110011, 7'b0001111:             dec_in.src = IMM_I;
            7'b0100011:                         dec_in.src = IMM_S;
            7'b1100011:                         dec_in.src = IMM_B;
            7'b1101111:                         dec_in.src = IMM_J;
            7'b0110111, 7'b0010111:             dec_in.src = IMM_U;
            7'b1110011:                         dec_in.src = i_instr[14] ? IMM_CSR : IMM_I;
            default:                            dec_in.illegal = 1'b1;
        endcase
        if (i_instr[1:0] != 2'b11) begin
            dec_in.illegal = 1'b1;
            dec_in.src     = IMM_I;
        end
    end

    assign accept  = i_valid && ready_q;
    assign consume = valid_q && i_ready;

    // valid_q/ready_q are updated alongside state so both outputs come
    // straight from flops rather than from a decode of the state encoding.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (i_flush) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= dec_in;
                        state   <= HALF;
                        valid_q <= 1'b1;
                    end
                end
                HALF: begin
                    if (accept && consume) begin
                        main_q <= dec_in;
                    end else if (accept) begin
                        skid_q  <= dec_in;
                        state   <= FULL;
                        ready_q <= 1'b0;
                    end else if (consume) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_q  <= skid_q;
                        state   <= HALF;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_imm     = main_q.instr[INSTR_WIDTH-1:7];
    assign o_imm_src = main_q.src;
    assign o_opcode  = main_q.instr[6:0];
    assign o_rd      = main_q.instr[11:7];
    assign o_rs1     = main_q.instr[19:15];
    assign o_rs2     = main_q.instr[24:20];
    assign o_func3   = main_q.instr[14:12];
    assign o_func7_5 = main_q.instr[30];
    assign o_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed and randomized bench for instr_decode_stage.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_flush = 1'b0;
    logic [31:0] i_instr = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic [24:0] o_imm;
    logic [2:0]  o_imm_src;
    logic [6:0]  o_opcode;
    logic [4:0]  o_rd;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [2:0]  o_func3;
    logic        o_func7_5;
    logic        o_illegal;

    int checks = 0;
    int errors = 0;

    instr_decode_stage #(.INSTR_WIDTH(32), .IMM_WIDTH(25)) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_flush   (i_flush),
        .i_instr   (i_instr),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_imm     (o_imm),
        .o_imm_src (o_imm_src),
        .o_opcode  (o_opcode),
        .o_rd      (o_rd),
        .o_rs1     (o_rs1),
        .o_rs2     (o_rs2),
        .o_func3   (o_func3),
        .o_func7_5 (o_func7_5),
        .o_illegal (o_illegal)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and land 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b1; i_instr = 32'h00500093; i_ready = 1'b1;
        step();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_imm !== 25'd0 || o_imm_src !== 3'b000 ||
            o_opcode !== 7'd0 || o_rd !== 5'd0 || o_rs1 !== 5'd0 || o_rs2 !== 5'd0 ||
            o_func3 !== 3'd0 || o_func7_5 !== 1'b0 || o_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_during: valid=%b ready=%b imm=%h src=%b op=%h ill=%b (want 0 1 0 0 0 0)",
                     o_valid, o_ready, o_imm, o_imm_src, o_opcode, o_illegal);
        end
        i_valid = 1'b0;
        step();
        i_rst = 1'b0;
        step();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_imm !== 25'd0 || o_opcode !== 7'd0) begin
            errors++;
            $display("FAIL reset_after: valid=%b ready=%b imm=%h op=%h (want 0 1 0 0)",
                     o_valid, o_ready, o_imm, o_opcode);
        end
    endtask

    task automatic test_stream();
        logic [31:0] words [5];
        logic [2:0]  srcs  [5];
        logic [4:0]  rds   [5];
        logic [31:0] w;
        words = '{32'h00500093, 32'h00112223, 32'hFE0098E3, 32'h008000EF, 32'h123452B7};
        srcs  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        rds   = '{5'd1, 5'd4, 5'd17, 5'd1, 5'd5};
        i_ready = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            w = words[k];
            i_valid = 1'b1; i_instr = w;
            step();
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_imm !== w[31:7] || o_imm_src !== srcs[k] ||
                o_rd !== rds[k] || o_opcode !== w[6:0] || o_rs1 !== w[19:15] || o_rs2 !== w[24:20] ||
                o_func3 !== w[14:12] || o_func7_5 !== w[30] || o_illegal !== 1'b0) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b imm=%h src=%b rd=%0d ill=%b (want 1 %h %b %0d 0)",
                         k, o_valid, o_imm, o_imm_src, o_rd, o_illegal, w[31:7], srcs[k], rds[k]);
            end
        end
        i_valid = 1'b0;
        step();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_csr_illegal();
        logic [31:0] words [4];
        logic [2:0]  srcs  [4];
        logic        ills  [4];
        words = '{32'h3400D073, 32'h34001073, 32'hFFFFFFFF, 32'h00500090};
        srcs  = '{3'b101, 3'b000, 3'b000, 3'b000};
        ills  = '{1'b0, 1'b0, 1'b1, 1'b1};
        i_ready = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_instr = words[k];
            step();
            checks++;
            if (o_valid !== 1'b1 || o_imm_src !== srcs[k] || o_illegal !== ills[k] ||
                {o_imm, o_opcode} !== words[k]) begin
                errors++;
                $display("FAIL csr_ill_%0d: valid=%b src=%b ill=%b word=%h (want 1 %b %b %h)",
                         k, o_valid, o_imm_src, o_illegal, {o_imm, o_opcode}, srcs[k], ills[k], words[k]);
            end
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic r0;
        i_ready = 1'b0;
        i_valid = 1'b1; i_instr = 32'h00A00113;
        step();
        checks++;
        if (o_valid !== 1'b1 || o_ready !== 1'b1 || {o_imm, o_opcode} !== 32'h00A00113) begin
            errors++;
            $display("FAIL bp_half: valid=%b ready=%b word=%h (want 1 1 00a00113)", o_valid, o_ready, {o_imm, o_opcode});
        end
        i_instr = 32'h00B00193;
        step();
        checks++;
        if (o_valid !== 1'b1 || o_ready !== 1'b0 || {o_imm, o_opcode} !== 32'h00A00113) begin
            errors++;
            $display("FAIL bp_full: valid=%b ready=%b word=%h (want 1 0 00a00113)", o_valid, o_ready, {o_imm, o_opcode});
        end
        // Word offered while full must not be taken.
        i_instr = 32'h00C00213;
        r0 = o_ready;
        i_ready = 1'b1; #1;
        checks++;
        if (o_ready !== r0) begin
            errors++;
            $display("FAIL bp_comb_ready: ready=%b changed with i_ready, want %b", o_ready, r0);
        end
        i_ready = 1'b0;
        step();
        checks++;
        if (o_ready !== 1'b0 || {o_imm, o_opcode} !== 32'h00A00113) begin
            errors++;
            $display("FAIL bp_hold: ready=%b word=%h (want 0 00a00113)", o_ready, {o_imm, o_opcode});
        end
        i_valid = 1'b0; i_ready = 1'b1;
        step();
        checks++;
        if (o_valid !== 1'b1 || o_ready !== 1'b1 || {o_imm, o_opcode} !== 32'h00B00193) begin
            errors++;
            $display("FAIL bp_word2: valid=%b ready=%b word=%h (want 1 1 00b00193)", o_valid, o_ready, {o_imm, o_opcode});
        end
        step();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty: valid=%b ready=%b (want 0 1)", o_valid, o_ready);
        end
    endtask

    task automatic test_flush();
        i_ready = 1'b0; i_valid = 1'b1;
        i_instr = 32'h00100293; step();
        i_instr = 32'h00200313; step();
        i_flush = 1'b1; i_instr = 32'h00300393; i_ready = 1'b1;
        step();
        i_flush = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: valid=%b ready=%b (want 0 1)", o_valid, o_ready);
        end
        i_valid = 1'b0;
        step();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_ghost: valid=%b word=%h want valid 0", o_valid, {o_imm, o_opcode});
        end
        i_valid = 1'b1; i_instr = 32'h00400413;
        step();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || {o_imm, o_opcode} !== 32'h00400413) begin
            errors++;
            $display("FAIL flush_next: valid=%b word=%h (want 1 00400413)", o_valid, {o_imm, o_opcode});
        end
        step();
    endtask

    task automatic test_reset_midstream();
        i_ready = 1'b0; i_valid = 1'b1;
        i_instr = 32'h00500493; step();
        i_instr = 32'h00600513; step();
        i_rst = 1'b1; i_flush = 1'b1; i_instr = 32'h00700593;
        step();
        i_rst = 1'b0; i_flush = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_imm !== 25'd0 || o_opcode !== 7'd0 ||
            o_imm_src !== 3'b000 || o_illegal !== 1'b0 || o_rd !== 5'd0 || o_func7_5 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b ready=%b imm=%h op=%h src=%b ill=%b (want 0 1 0 0 0 0)",
                     o_valid, o_ready, o_imm, o_opcode, o_imm_src, o_illegal);
        end
        i_ready = 1'b1; i_instr = 32'h00800613;
        step();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || {o_imm, o_opcode} !== 32'h00800613) begin
            errors++;
            $display("FAIL rst_first: valid=%b word=%h (want 1 00800613)", o_valid, {o_imm, o_opcode});
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] exp_q [$];
        logic [31:0] pool [6];
        logic [31:0] w;
        logic        v;
        logic        r;
        logic        r0;
        logic        acc;
        logic        con;
        pool = '{32'h00500093, 32'h00112223, 32'hFE0098E3, 32'h008000EF, 32'h123452B7, 32'h3400D073};
        i_valid = 1'b0; i_ready = 1'b0;
        for (int unsigned c = 0; c < 10000; c++) begin
            checks++;
            if (o_ready !== (exp_q.size() < 2) || o_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_hs cyc %0d: valid=%b ready=%b occupancy=%0d", c, o_valid, o_ready, exp_q.size());
            end
            if (exp_q.size() != 0) begin
                checks++;
                if ({o_imm, o_opcode} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_data cyc %0d: word=%h want %h", c, {o_imm, o_opcode}, exp_q[0]);
                end
            end
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 5)] : $urandom;
            i_valid = v; i_instr = w;
            r0 = o_ready;
            i_ready = ~r; #1;
            checks++;
            if (o_ready !== r0) begin
                errors++;
                $display("FAIL rand_comb_ready cyc %0d: ready=%b want %b", c, o_ready, r0);
            end
            i_ready = r;
            acc = v && (exp_q.size() < 2);
            con = r && (exp_q.size() != 0);
            step();
            if (con) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(w);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        step(); step();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand_drain: valid=%b ready=%b (want 0 1)", o_valid, o_ready);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_csr_illegal();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
